game_ctrl: RTL
==============

Name: game_ctrl

Overview:
Game controller that sits directly downstream of the per-lane car movers and directly upstream of them via the level bus. Each cycle it compares the frog position against every lane's car position to detect collisions and goal arrival. It tracks lives and level (1..MAX_LEVEL) and drives the shared level bus read by every car instance. It also issues a one-cycle frog-respawn pulse to the frog/input block.

Parameters:
NUM_LANES, 4, number of car lanes; lane k (0-based) occupies grid row k+1; row 0 = start, row NUM_LANES+1 = goal
LIVES, 3, lives granted at game start (1..7)
MAX_LEVEL, 16, level saturation value (≤127)
HOLD_CYCLES, 25'd12_500_000, cycles spent in HIT/WIN display hold (0.5 s at 25 MHz)

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset, asynchronous, active-high
i_start  in  1  start/restart request, level-sensitive, sampled in IDLE and GAME_OVER only
i_frog_x  in  5  frog column 0..19
i_frog_y  in  4  frog row 0..NUM_LANES+1
i_car_x  in  5*NUM_LANES  packed car columns, lane k at bits [5k+4:5k]
o_level  out  7  current level, feeds car level inputs
o_lives  out  3  remaining lives
o_state  out  3  state encoding (display/debug)
o_collision  out  1  one-cycle pulse on detected hit
o_frog_reset  out  1  one-cycle pulse: frog returns to (10,0)
o_game_over  out  1  high while in GAME_OVER

Behaviour:
- Reset (async, i_Rst=1): state=IDLE, o_level=1, o_lives=LIVES, hold counter=0, all pulses 0, o_game_over=0.
- Hit detect: registered stage; hit_q <= OR over k of (i_frog_y==k+1 && i_frog_x==car_x[k]). Goal detect: goal_q <= (i_frog_y==NUM_LANES+1). Both 1-cycle latency; the FSM acts on the registered values.
- States: IDLE=0, PLAY=1, HIT=2, WIN=3, GAME_OVER=4.
- IDLE: i_start=1 -> PLAY and pulse o_frog_reset in the same transition cycle.
- PLAY: hit_q=1 -> pulse o_collision and decrement lives. If the new lives value is 0, go to GAME_OVER. Otherwise go to HIT and load counter=HOLD_CYCLES-1.
- PLAY: goal_q=1 (hit_q=0) -> o_level <= min(o_level+1, MAX_LEVEL); go to WIN and load the counter.
- hit_q and goal_q are mutually exclusive by row; hit_q has priority if both are ever asserted.
- HIT/WIN: counter decrements each cycle. At 0: pulse o_frog_reset and return to PLAY. hit_q/goal_q are ignored during the hold, so there are no double decrements.
- GAME_OVER: o_game_over=1; car level is held. i_start=1 -> o_level=1, o_lives=LIVES, pulse o_frog_reset, go to PLAY.
- i_start is ignored in PLAY/HIT/WIN.
- Level at MAX_LEVEL stays at MAX_LEVEL on further wins; the WIN hold still occurs.
- Lives never underflow; the 0 case always routes to GAME_OVER.
- HOLD_CYCLES=0 is treated as 1.
- i_Rst asserted mid-hold or mid-game returns immediately to IDLE with reset values. A pending pulse is dropped.
- o_frog_reset and o_collision are never high for more than one consecutive cycle.

Optional Feature:
GAME_CTRL_SCORE_EN.
- Defined: adds output o_score (7 bits, binary, saturating at 99 for two-digit 7-seg). Score +1 on each WIN entry and cleared by reset and by restart from GAME_OVER.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared header game_defs.vh: GRID_W=20, X_W=5, Y_W=4, LVL_W=7, FROG_START_X=10, state encodings.
- The car movers include the same header for the grid width.
- One sub-module, lane_hit_detect: parameterised NUM_LANES; registered hit_q/goal_q outputs with async reset. The FSM, counter and score stay in game_ctrl.

Test Plan:
All scenarios use HOLD_CYCLES=4.
- Reset mid-game: assert i_Rst asynchronously during HIT hold -> o_level=1, o_lives=3, o_state=0 without waiting for a clock edge; no o_frog_reset pulse afterwards.
- Start plus single hit: i_start in IDLE -> o_frog_reset one pulse. Frog (7,2), lane1 car_x=7 -> o_collision pulse 2 cycles later, o_lives=2, state HIT for 4 cycles, then o_frog_reset pulse, state PLAY.
- Near miss: frog (7,2), lane1 car=8, lane0 car=7 -> no collision over 100 cycles.
- Win path and saturation: frog_y=5 (goal) -> o_level 1->2, WIN hold 4 cycles, respawn pulse. Repeat 20 wins -> o_level saturates at 16; with GAME_CTRL_SCORE_EN, o_score=20.
- Game over and restart: three hits -> o_lives 3->2->1->0, o_game_over=1, level frozen. i_start -> o_lives=3, o_level=1, o_game_over=0, respawn pulse.
- Hold immunity: hit held continuously through HIT -> exactly one decrement per hold period.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game controller: grid field widths, FSM state encodings
// and the saturating level step used on each goal.
package game_ctrl_pkg;

  localparam int X_W       = 5;
  localparam int Y_W       = 4;
  localparam int LVL_W     = 7;
  localparam int LIVES_W   = 3;
  localparam int SCORE_W   = 7;
  localparam int SCORE_MAX = 99;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HIT       = 3'd2,
    ST_WIN       = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  function automatic logic [LVL_W-1:0] level_inc(input logic [LVL_W-1:0] lvl,
                                                 input logic [LVL_W-1:0] max_lvl);
    return (lvl >= max_lvl) ? max_lvl : lvl + LVL_W'(1);
  endfunction

endpackage

// File: rtl/lane_hit_detect.sv
// Registered collision/goal detector: compares the frog cell against the car in every lane
// row and flags arrival on the goal row, one cycle after the positions are presented.
module lane_hit_detect
  import game_ctrl_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic [X_W-1:0]           frog_x,
  input  logic [Y_W-1:0]           frog_y,
  input  logic [X_W*NUM_LANES-1:0] car_x,
  output logic                     hit_q,
  output logic                     goal_q
);

  localparam logic [Y_W-1:0] GOAL_ROW = Y_W'(NUM_LANES + 1);

  logic [NUM_LANES-1:0] lane_match;

  // Lane k lives on row k+1; row 0 is the start bank.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [Y_W-1:0] LANE_ROW = Y_W'(gi + 1);
      assign lane_match[gi] = (frog_y == LANE_ROW) && (frog_x == car_x[X_W*gi +: X_W]);
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hit_q  <= 1'b0;
      goal_q <= 1'b0;
    end else begin
      hit_q  <= |lane_match;
      goal_q <= (frog_y == GOAL_ROW);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: tracks lives and level, drives the shared level bus and respawn/collision
// pulses. Optional saturating score output enabled by the GAME_CTRL_SCORE_EN macro.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int          NUM_LANES   = 4,
  parameter int          LIVES       = 3,
  parameter int          MAX_LEVEL   = 16,
  parameter int unsigned HOLD_CYCLES = 12_500_000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_start,
  input  logic [X_W-1:0]           i_frog_x,
  input  logic [Y_W-1:0]           i_frog_y,
  input  logic [X_W*NUM_LANES-1:0] i_car_x,
  output logic [LVL_W-1:0]         o_level,
  output logic [LIVES_W-1:0]       o_lives,
  output logic [2:0]               o_state,
  output logic                     o_collision,
  output logic                     o_frog_reset,
`ifdef GAME_CTRL_SCORE_EN
  output logic [SCORE_W-1:0]       o_score,
`endif
  output logic                     o_game_over
);

  // A zero hold is stretched to a single cycle so the respawn still happens after the hold.
  localparam int unsigned        HOLD_EFF   = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int                 CNT_W      = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_EFF - 1);
  localparam logic [LVL_W-1:0]   LVL_MAX    = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0]   LVL_START  = LVL_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  game_state_t          state_reg, state_next;
  logic [LIVES_W-1:0]   lives_reg, lives_next;
  logic [LVL_W-1:0]     level_reg, level_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 collision_reg, collision_next;
  logic                 frog_reset_reg, frog_reset_next;
  logic                 hit_q, goal_q;
`ifdef GAME_CTRL_SCORE_EN
  logic [SCORE_W-1:0]   score_reg, score_next;
`endif

  lane_hit_detect #(
    .NUM_LANES (NUM_LANES)
  ) u_lane_hit_detect (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .frog_x (i_frog_x),
    .frog_y (i_frog_y),
    .car_x  (i_car_x),
    .hit_q  (hit_q),
    .goal_q (goal_q)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_reg      <= ST_IDLE;
      lives_reg      <= LIVES_INIT;
      level_reg      <= LVL_START;
      cnt_reg        <= '0;
      collision_reg  <= 1'b0;
      frog_reset_reg <= 1'b0;
`ifdef GAME_CTRL_SCORE_EN
      score_reg      <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      level_reg      <= level_next;
      cnt_reg        <= cnt_next;
      collision_reg  <= collision_next;
      frog_reset_reg <= frog_reset_next;
`ifdef GAME_CTRL_SCORE_EN
      score_reg      <= score_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    lives_next      = lives_reg;
    level_next      = level_reg;
    cnt_next        = cnt_reg;
    collision_next  = 1'b0;
    frog_reset_next = 1'b0;
`ifdef GAME_CTRL_SCORE_EN
    score_next      = score_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next      = ST_PLAY;
          frog_reset_next = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_q) begin
          collision_next = 1'b1;
          // The last life routes straight to GAME_OVER; the counter never wraps below zero.
          if (lives_reg <= LIVES_W'(1)) begin
            lives_next = '0;
            state_next = ST_GAME_OVER;
          end else begin
            lives_next = lives_reg - LIVES_W'(1);
            state_next = ST_HIT;
            cnt_next   = HOLD_LOAD;
          end
        end else if (goal_q) begin
          level_next = level_inc(level_reg, LVL_MAX);
          state_next = ST_WIN;
          cnt_next   = HOLD_LOAD;
`ifdef GAME_CTRL_SCORE_EN
          score_next = (score_reg >= SCORE_W'(SCORE_MAX)) ? score_reg
                                                           : score_reg + SCORE_W'(1);
`endif
        end
      end
      ST_HIT, ST_WIN: begin
        if (cnt_reg == '0) begin
          state_next      = ST_PLAY;
          frog_reset_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_GAME_OVER: begin
        if (i_start) begin
          state_next      = ST_PLAY;
          lives_next      = LIVES_INIT;
          level_next      = LVL_START;
          frog_reset_next = 1'b1;
`ifdef GAME_CTRL_SCORE_EN
          score_next      = '0;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_level      = level_reg;
  assign o_lives      = lives_reg;
  assign o_state      = state_reg;
  assign o_collision  = collision_reg;
  assign o_frog_reset = frog_reset_reg;
  assign o_game_over  = (state_reg == ST_GAME_OVER);
`ifdef GAME_CTRL_SCORE_EN
  assign o_score      = score_reg;
`endif

endmodule
